// File: rtl/ssd1306_pkg.sv
// Shared constants and types for the SSD1306 SPI receiver: opcodes,
// addressing modes and default geometry.
package ssd1306_pkg;

    localparam int DEF_COLS  = 128;
    localparam int DEF_PAGES = 8;

    localparam logic [7:0] SET_MEM_MODE    = 8'h20;
    localparam logic [7:0] SET_COL_ADDR    = 8'h21;
    localparam logic [7:0] SET_PAGE_ADDR   = 8'h22;
    localparam logic [7:0] DISPLAY_OFF     = 8'hAE;
    localparam logic [7:0] DISPLAY_ON      = 8'hAF;
    localparam logic [7:0] SET_CONTRAST    = 8'h81;
    localparam logic [7:0] CHARGE_PUMP     = 8'h8D;
    localparam logic [7:0] SET_MUX_RATIO   = 8'hA8;
    localparam logic [7:0] SET_DISP_OFFSET = 8'hD3;
    localparam logic [7:0] SET_CLK_DIV     = 8'hD5;
    localparam logic [7:0] SET_PRECHARGE   = 8'hD9;
    localparam logic [7:0] SET_COM_PINS    = 8'hDA;
    localparam logic [7:0] SET_VCOMH       = 8'hDB;

    typedef enum logic [1:0] {
        HORIZ = 2'd0,
        VERT  = 2'd1,
        PAGE  = 2'd2
    } addr_mode_t;

    typedef enum logic [1:0] {
        ST_CMD  = 2'd0,
        ST_ARG1 = 2'd1,
        ST_ARG2 = 2'd2
    } dec_state_t;

    // Commands whose single argument the receiver swallows without effect.
    function automatic logic is_one_arg(input logic [7:0] op);
        logic hit;
        hit = 1'b0;
        case (op)
            SET_CONTRAST, CHARGE_PUMP, SET_MUX_RATIO, SET_DISP_OFFSET,
            SET_CLK_DIV, SET_PRECHARGE, SET_COM_PINS, SET_VCOMH: hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/ssd1306_spi_receiver_deser.sv
// Oversampling SPI mode-0 deserializer: synchronizes the link, detects sclk
// rising edges and assembles MSB-first bytes tagged with the dc line.
module spi_byte_deserializer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       csn,
    input  logic       dc,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       rstn,
    output logic       byte_done,
    output logic [7:0] byte_data,
    output logic       byte_dc,
    output logic       link_rstn
);

    logic [SYNC_STAGES-1:0] csn_s, dc_s, sclk_s, mosi_s, rstn_s;
    logic       sync_csn, sync_dc, sync_sclk, sync_mosi;
    logic       sclk_prev, sclk_rise;
    logic [2:0] bit_cnt;
    logic [6:0] shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csn_s  <= '1;
            dc_s   <= '0;
            sclk_s <= '0;
            mosi_s <= '0;
            rstn_s <= '0;
        end else begin
            csn_s  <= {csn_s[SYNC_STAGES-2:0], csn};
            dc_s   <= {dc_s[SYNC_STAGES-2:0], dc};
            sclk_s <= {sclk_s[SYNC_STAGES-2:0], sclk};
            mosi_s <= {mosi_s[SYNC_STAGES-2:0], mosi};
            rstn_s <= {rstn_s[SYNC_STAGES-2:0], rstn};
        end
    end

    assign sync_csn  = csn_s[SYNC_STAGES-1];
    assign sync_dc   = dc_s[SYNC_STAGES-1];
    assign sync_sclk = sclk_s[SYNC_STAGES-1];
    assign sync_mosi = mosi_s[SYNC_STAGES-1];
    assign link_rstn = rstn_s[SYNC_STAGES-1];
    assign sclk_rise = sync_sclk & ~sclk_prev;

    // The csn sample of the current cycle qualifies the edge, so a byte whose
    // 8th edge lands before csn rises in the synchronizer still completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_prev <= 1'b0;
            bit_cnt   <= 3'd0;
            shreg     <= 7'd0;
            byte_done <= 1'b0;
            byte_data <= 8'd0;
            byte_dc   <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            sclk_prev <= sync_sclk;
            if (!link_rstn || sync_csn) begin
                bit_cnt <= 3'd0;
            end else if (sclk_rise) begin
                shreg   <= {shreg[5:0], sync_mosi};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_done <= 1'b1;
                    byte_data <= {shreg, sync_mosi};
                    byte_dc   <= sync_dc;
                end
            end
        end
    end

endmodule

// File: rtl/ssd1306_spi_receiver.sv
// Display-side SSD1306 4-wire SPI receiver: decodes the addressing command
// subset and turns GDDRAM data bytes into framebuffer write strobes.
module ssd1306_spi_receiver
    import ssd1306_pkg::*;
#(
    parameter int COLS        = DEF_COLS,
    parameter int PAGES       = DEF_PAGES,
    parameter int SYNC_STAGES = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             oled_csn_in,
    input  logic                             oled_dc_in,
    input  logic                             oled_clk_in,
    input  logic                             oled_mosi_in,
    input  logic                             oled_rstn_in,
    output logic                             fb_we_out,
    output logic [$clog2(COLS*PAGES)-1:0]    fb_addr_out,
    output logic [7:0]                       fb_data_out,
    output logic                             cmd_valid_out,
    output logic [7:0]                       cmd_byte_out,
    output logic                             display_on_out,
    output logic [1:0]                       addr_mode_out,
    output logic                             frame_done_out
);

    localparam int CW = $clog2(COLS);
    localparam int PW = $clog2(PAGES);

    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [CW-1:0] COL_MAX  = CW'(COLS - 1);
    localparam logic [CW-1:0] LO_MASK  = CW'(8'h0F);
    localparam logic [CW-1:0] HI_MASK  = CW'(8'hF0);
    localparam logic [PW-1:0] PAGE_ONE = PW'(1);

    logic       byte_done, byte_dc, link_rstn;
    logic [7:0] byte_data;

    spi_byte_deserializer #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_deser (
        .clk       (clk),
        .rst_n     (rst_n),
        .csn       (oled_csn_in),
        .dc        (oled_dc_in),
        .sclk      (oled_clk_in),
        .mosi      (oled_mosi_in),
        .rstn      (oled_rstn_in),
        .byte_done (byte_done),
        .byte_data (byte_data),
        .byte_dc   (byte_dc),
        .link_rstn (link_rstn)
    );

    dec_state_t    state;
    logic [7:0]    opcode, arg1;
    logic [CW-1:0] col, col_start, col_end;
    logic [PW-1:0] page, page_start, page_end;
    logic          last_col, last_page;

    assign last_col  = (col == col_end);
    assign last_page = (page == page_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_CMD;
            opcode         <= 8'd0;
            arg1           <= 8'd0;
            col            <= '0;
            col_start      <= '0;
            col_end        <= COL_MAX;
            page           <= '0;
            page_start     <= '0;
            page_end       <= PW'(PAGES - 1);
            fb_we_out      <= 1'b0;
            fb_addr_out    <= '0;
            fb_data_out    <= 8'd0;
            cmd_valid_out  <= 1'b0;
            cmd_byte_out   <= 8'd0;
            display_on_out <= 1'b0;
            addr_mode_out  <= PAGE;
            frame_done_out <= 1'b0;
        end else if (!link_rstn) begin
            // Display reset line held low: everything parks at power-on values.
            state          <= ST_CMD;
            opcode         <= 8'd0;
            arg1           <= 8'd0;
            col            <= '0;
            col_start      <= '0;
            col_end        <= COL_MAX;
            page           <= '0;
            page_start     <= '0;
            page_end       <= PW'(PAGES - 1);
            fb_we_out      <= 1'b0;
            fb_addr_out    <= '0;
            fb_data_out    <= 8'd0;
            cmd_valid_out  <= 1'b0;
            cmd_byte_out   <= 8'd0;
            display_on_out <= 1'b0;
            addr_mode_out  <= PAGE;
            frame_done_out <= 1'b0;
        end else begin
            fb_we_out      <= 1'b0;
            cmd_valid_out  <= 1'b0;
            frame_done_out <= 1'b0;
            if (byte_done && byte_dc) begin
                // Data byte; also abandons any half-received command.
                state          <= ST_CMD;
                fb_we_out      <= 1'b1;
                fb_addr_out    <= {page, col};
                fb_data_out    <= byte_data;
                frame_done_out <= (addr_mode_out == HORIZ || addr_mode_out == VERT)
                                  && last_col && last_page;
                case (addr_mode_out)
                    HORIZ: begin
                        if (last_col) begin
                            col  <= col_start;
                            page <= last_page ? page_start : page + PAGE_ONE;
                        end else begin
                            col <= col + COL_ONE;
                        end
                    end
                    VERT: begin
                        if (last_page) begin
                            page <= page_start;
                            col  <= last_col ? col_start : col + COL_ONE;
                        end else begin
                            page <= page + PAGE_ONE;
                        end
                    end
                    default: col <= (col == COL_MAX) ? col_start : col + COL_ONE;
                endcase
            end else if (byte_done) begin
                cmd_valid_out <= 1'b1;
                cmd_byte_out  <= byte_data;
                case (state)
                    ST_CMD: begin
                        opcode <= byte_data;
                        if (byte_data == SET_MEM_MODE || byte_data == SET_COL_ADDR ||
                            byte_data == SET_PAGE_ADDR || is_one_arg(byte_data)) begin
                            state <= ST_ARG1;
                        end else if (byte_data[7:4] == 4'h0) begin
                            col <= (col & ~LO_MASK) | (CW'(byte_data[3:0]) & LO_MASK);
                        end else if (byte_data[7:4] == 4'h1) begin
                            col <= (col & ~HI_MASK) | (CW'({byte_data[3:0], 4'h0}) & HI_MASK);
                        end else if (byte_data[7:3] == 5'b10110) begin
                            page <= PW'(byte_data[2:0]);
                        end else if (byte_data == DISPLAY_OFF) begin
                            display_on_out <= 1'b0;
                        end else if (byte_data == DISPLAY_ON) begin
                            display_on_out <= 1'b1;
                        end
                    end
                    ST_ARG1: begin
                        arg1 <= byte_data;
                        if (opcode == SET_COL_ADDR || opcode == SET_PAGE_ADDR) begin
                            state <= ST_ARG2;
                        end else begin
                            state <= ST_CMD;
                            if (opcode == SET_MEM_MODE)
                                addr_mode_out <= byte_data[1:0];
                        end
                    end
                    ST_ARG2: begin
                        state <= ST_CMD;
                        if (opcode == SET_COL_ADDR) begin
                            col_start <= CW'(arg1);
                            col_end   <= CW'(byte_data);
                            col       <= CW'(arg1);
                        end else begin
                            page_start <= PW'(arg1);
                            page_end   <= PW'(byte_data);
                            page       <= PW'(arg1);
                        end
                    end
                    default: state <= ST_CMD;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ssd1306_spi_receiver.sv
// Scoreboard bench for the SSD1306 SPI receiver: a command-list reference
// model queues expected strobes, an independent monitor checks them.
module tb_ssd1306_spi_receiver;

    localparam int COLS  = 128;
    localparam int PAGES = 8;
    localparam int SS    = 2;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       csn = 1'b1, dc = 1'b0, sclk = 1'b0, mosi = 1'b0, rstn = 1'b1;
    logic       fb_we, cmd_valid, display_on, frame_done;
    logic [9:0] fb_addr;
    logic [7:0] fb_data, cmd_byte;
    logic [1:0] addr_mode;

    ssd1306_spi_receiver #(.COLS(COLS), .PAGES(PAGES), .SYNC_STAGES(SS)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .oled_csn_in    (csn),
        .oled_dc_in     (dc),
        .oled_clk_in    (sclk),
        .oled_mosi_in   (mosi),
        .oled_rstn_in   (rstn),
        .fb_we_out      (fb_we),
        .fb_addr_out    (fb_addr),
        .fb_data_out    (fb_data),
        .cmd_valid_out  (cmd_valid),
        .cmd_byte_out   (cmd_byte),
        .display_on_out (display_on),
        .addr_mode_out  (addr_mode),
        .frame_done_out (frame_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit is_fb;
        int val;    // fb address or command byte
        int data;
        bit frame;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;

    int m_col, m_page, m_cs, m_ce, m_ps, m_pe, m_mode, m_on;
    int pend[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nargs(input int op);
        case (op)
            'h20, 'h81, 'h8D, 'hA8, 'hD3, 'hD5, 'hD9, 'hDA, 'hDB: return 1;
            'h21, 'h22: return 2;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_col = 0; m_page = 0; m_cs = 0; m_ce = COLS - 1;
        m_ps = 0; m_pe = PAGES - 1; m_mode = 2; m_on = 0;
        pend.delete();
    endtask

    task automatic model_cmd(input int b);
        ev_t e;
        e.is_fb = 1'b0; e.val = b; e.data = 0; e.frame = 1'b0;
        exp_q.push_back(e);
        if (pend.size() == 0) begin
            if (nargs(b) > 0) pend.push_back(b);
            else if (b < 16) m_col = ((m_col / 16) * 16 + b) % COLS;
            else if (b < 32) m_col = ((b - 16) * 16 + m_col % 16) % COLS;
            else if (b >= 'hB0 && b <= 'hB7) m_page = (b - 'hB0) % PAGES;
            else if (b == 'hAE) m_on = 0;
            else if (b == 'hAF) m_on = 1;
        end else begin
            pend.push_back(b);
            if (pend.size() == nargs(pend[0]) + 1) begin
                if (pend[0] == 'h20) m_mode = pend[1] % 4;
                else if (pend[0] == 'h21) begin
                    m_cs = pend[1] % COLS; m_ce = pend[2] % COLS; m_col = m_cs;
                end else if (pend[0] == 'h22) begin
                    m_ps = pend[1] % PAGES; m_pe = pend[2] % PAGES; m_page = m_ps;
                end
                pend.delete();
            end
        end
    endtask

    task automatic model_data(input int b);
        ev_t e;
        e.is_fb = 1'b1;
        e.val   = m_page * COLS + m_col;
        e.data  = b;
        e.frame = (m_mode < 2) && (m_col == m_ce) && (m_page == m_pe);
        exp_q.push_back(e);
        pend.delete();
        if (m_mode == 0) begin
            if (m_col == m_ce) begin
                m_col  = m_cs;
                m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % PAGES;
            end else m_col = (m_col + 1) % COLS;
        end else if (m_mode == 1) begin
            if (m_page == m_pe) begin
                m_page = m_ps;
                m_col  = (m_col == m_ce) ? m_cs : (m_col + 1) % COLS;
            end else m_page = (m_page + 1) % PAGES;
        end else begin
            m_col = (m_col == COLS - 1) ? m_cs : m_col + 1;
        end
    endtask

    // Monitor: every strobe the DUT presents must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fb_we) begin
                if (exp_q.size() == 0) check("fb_unexpected", 1, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    check("fb_kind", 1, int'(mon_e.is_fb));
                    check("fb_addr", int'(fb_addr), mon_e.val);
                    check("fb_data", int'(fb_data), mon_e.data);
                    check("frame_done", int'(frame_done), int'(mon_e.frame));
                end
            end else if (frame_done) begin
                check("frame_stray", 1, 0);
            end
            if (cmd_valid) begin
                if (exp_q.size() == 0) check("cmd_unexpected", 1, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    check("cmd_kind", 0, int'(mon_e.is_fb));
                    check("cmd_byte", int'(cmd_byte), mon_e.val);
                end
            end
        end
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bits(input int b, input bit d, input int n);
        dc = d;
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            sclk = 1'b0;
            wclk(4);
            sclk = 1'b1;
            wclk(4);
        end
        sclk = 1'b0;
        wclk(2);
    endtask

    task automatic send(input int b, input bit d);
        if (d) model_data(b);
        else model_cmd(b);
        csn = 1'b0;
        wclk(3);
        spi_bits(b, d, 8);
        csn = 1'b1;
        wclk(SS + 6);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_display_on"}, int'(display_on), m_on);
        check({tag, "_addr_mode"}, int'(addr_mode), m_mode);
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic check_reset_outs();
        check("rst_fb_we", int'(fb_we), 0);
        check("rst_fb_addr", int'(fb_addr), 0);
        check("rst_fb_data", int'(fb_data), 0);
        check("rst_cmd_valid", int'(cmd_valid), 0);
        check("rst_cmd_byte", int'(cmd_byte), 0);
        check("rst_display_on", int'(display_on), 0);
        check("rst_addr_mode", int'(addr_mode), 2);
        check("rst_frame_done", int'(frame_done), 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        bit d;
        int one_arg[8] = '{'h81, 'h8D, 'hA8, 'hD3, 'hD5, 'hD9, 'hDA, 'hDB};

        model_reset();
        wclk(3);
        check_reset_outs();
        rst_n = 1'b1;
        wclk(5);

        // Page-mode pointer set, two data bytes -> 402, 403
        send('hB3, 0); send('h02, 0); send('h11, 0);
        send('h55, 1); send('hAA, 1);
        check_state("page");

        // Horizontal window at the bottom-right corner, wraps after frame
        send('h20, 0); send('h00, 0);
        send('h21, 0); send('h7E, 0); send('h7F, 0);
        send('h22, 0); send('h06, 0); send('h07, 0);
        for (int i = 0; i < 5; i++) send(i + 1, 1);
        check_state("horiz");

        // Vertical mode, full ranges
        send('h20, 0); send('h01, 0);
        send('h21, 0); send('h00, 0); send('h7F, 0);
        send('h22, 0); send('h00, 0); send('h07, 0);
        for (int i = 0; i < 9; i++) send('h30 + i, 1);
        check_state("vert");

        // Partial byte dropped by csn, then display on
        csn = 1'b0; wclk(3);
        spi_bits('hFF, 0, 5);
        csn = 1'b1; wclk(SS + 6);
        send('hAF, 0);
        check_state("partial");

        // Column command abandoned by a data byte
        send('h21, 0); send('h10, 0); send('h99, 1);
        send('h9A, 1); send('h9B, 1);
        check_state("abandon");

        // Display reset pulsed mid-byte
        csn = 1'b0; wclk(3);
        spi_bits('hA5, 0, 3);
        rstn = 1'b0;
        model_reset();
        wclk(8);
        check_state("rstn_low");
        rstn = 1'b1;
        wclk(4);
        spi_bits('h5A, 0, 4);
        csn = 1'b1; wclk(SS + 6);
        send('hAF, 0);
        send('h40, 1);
        check_state("rstn_after");

        // System reset asserted mid-transfer
        csn = 1'b0; wclk(3);
        spi_bits('hC3, 0, 4);
        rst_n = 1'b0;
        model_reset();
        exp_q.delete();
        #2;
        check_reset_outs();
        wclk(2);
        rst_n = 1'b1;
        wclk(2);
        spi_bits('h3C, 0, 4);
        csn = 1'b1; wclk(SS + 6);
        send('hAF, 0);
        send('h41, 1);
        check_state("rst_after");

        // Randomized traffic against the reference model
        for (int n = 0; n < 250; n++) begin
            d = ($urandom_range(0, 99) < 50);
            if (d) b = int'($urandom_range(0, 255));
            else begin
                case ($urandom_range(0, 9))
                    0: b = 'h20;
                    1: b = 'h21;
                    2: b = 'h22;
                    3: b = int'($urandom_range(0, 31));
                    4: b = 'hB0 + int'($urandom_range(0, 7));
                    5: b = 'hAE;
                    6: b = 'hAF;
                    7: b = one_arg[$urandom_range(0, 7)];
                    default: b = int'($urandom_range(0, 255));
                endcase
            end
            send(b, d);
        end
        wclk(10);
        check_state("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
